// File: rtl/mem_noc_router_1ton_pkg.sv
// Shared request/response types and the default address map for the 1-to-N memory NoC router.
package mem_noc_router_1ton_pkg;

  localparam int unsigned AddrW        = 32;
  localparam int unsigned DataW        = 32;
  localparam int unsigned MaxSn        = 8;
  localparam int unsigned MaxOutstdDef = 4;

  typedef logic [$clog2(MaxSn + 1)-1:0] noc_tgt_t;

  typedef struct packed {
    logic [AddrW-1:0]   req_addr;
    logic               req_we;
    logic [DataW-1:0]   req_wdata;
    logic [DataW/8-1:0] req_be;
  } mem_req_t;

  typedef struct packed {
    logic [DataW-1:0] resp_rdata;
    logic             resp_err;
  } mem_resp_t;

  // Slave i owns the 256 MiB window starting at i << 28.
  localparam logic [MaxSn-1:0][AddrW-1:0] SnBaseDef = {
    32'h7000_0000, 32'h6000_0000, 32'h5000_0000, 32'h4000_0000,
    32'h3000_0000, 32'h2000_0000, 32'h1000_0000, 32'h0000_0000
  };
  localparam logic [MaxSn-1:0][AddrW-1:0] SnMaskDef = {MaxSn{32'hF000_0000}};

endpackage

// File: rtl/noc_tid_fifo.sv
// In-order FIFO of target IDs for outstanding requests; DEPTH must be a power of two so the
// pointers wrap naturally.
module noc_tid_fifo #(
  parameter int unsigned WIDTH = 3,
  parameter int unsigned DEPTH = 4
) (
  input  logic                         clk,
  input  logic                         rstn,
  input  logic                         push,
  input  logic [WIDTH-1:0]             push_data,
  input  logic                         pop,
  output logic                         full,
  output logic                         empty,
  output logic [$clog2(DEPTH+1)-1:0]   count,
  output logic [WIDTH-1:0]             head
);

  localparam int unsigned PtrW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CntW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PtrW-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic             push_en, pop_en;

  assign full    = (cnt_q == CntW'(DEPTH));
  assign empty   = (cnt_q == '0);
  assign push_en = push && !full;
  assign pop_en  = pop && !empty;
  assign count   = cnt_q;
  assign head    = mem_q[rd_ptr_q];

  always_comb begin
    wr_ptr_d = push_en ? wr_ptr_q + PtrW'(1) : wr_ptr_q;
    rd_ptr_d = pop_en ? rd_ptr_q + PtrW'(1) : rd_ptr_q;
    cnt_d    = cnt_q;
    case ({push_en, pop_en})
      2'b10:   cnt_d = cnt_q + CntW'(1);
      2'b01:   cnt_d = cnt_q - CntW'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  // Payload storage: resettable flops with a per-write enable.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else if (push_en) begin
      mem_q[wr_ptr_q] <= push_data;
    end
  end

endmodule

// File: rtl/mem_noc_router_1ton.sv
// 1-to-N memory NoC router: address-decoded request fan-out, in-order response return.
// Define MEM_NOC_DECERR_EN to answer unmapped requests locally instead of routing them to the
// last slave.
module mem_noc_router_1ton
  import mem_noc_router_1ton_pkg::*;
#(
  parameter int unsigned                   NUM_SN     = 2,
  parameter int unsigned                   MAX_OUTSTD = MaxOutstdDef,
  parameter int unsigned                   SN_IDW     = $clog2(NUM_SN + 1),
  parameter logic [NUM_SN-1:0][AddrW-1:0]  SN_BASE    = SnBaseDef[NUM_SN-1:0],
  parameter logic [NUM_SN-1:0][AddrW-1:0]  SN_MASK    = SnMaskDef[NUM_SN-1:0]
) (
  input  logic                               clk,
  input  logic                               rstn,
  input  logic                               mn_req_valid,
  output logic                               mn_req_ready,
  input  mem_req_t                           mn_req,
  output logic                               mn_resp_valid,
  input  logic                               mn_resp_ready,
  output mem_resp_t                          mn_resp,
  output logic [NUM_SN-1:0]                  sn_req_valid,
  input  logic [NUM_SN-1:0]                  sn_req_ready,
  output mem_req_t                           sn_req [NUM_SN],
  input  logic [NUM_SN-1:0]                  sn_resp_valid,
  output logic [NUM_SN-1:0]                  sn_resp_ready,
  input  mem_resp_t                          sn_resp [NUM_SN],
  output logic [SN_IDW-1:0]                  sn_tid,
  output logic [$clog2(MAX_OUTSTD+1)-1:0]    outstd_cnt
);

`ifdef MEM_NOC_DECERR_EN
  localparam logic [SN_IDW-1:0] MissRoute = SN_IDW'(NUM_SN);
`else
  localparam logic [SN_IDW-1:0] MissRoute = SN_IDW'(NUM_SN - 1);
`endif

  logic [SN_IDW-1:0] tgt;
  logic [SN_IDW-1:0] head;
  logic              fifo_full, fifo_empty;
  logic              fwd_ready;
  logic              push, pop;

  // Scan from the top so the lowest matching index ends up winning.
  always_comb begin
    tgt = MissRoute;
    for (int i = NUM_SN - 1; i >= 0; i--) begin
      if ((mn_req.req_addr & SN_MASK[i]) == SN_BASE[i]) tgt = SN_IDW'(i);
    end
  end

  // Outputs are forced quiet while rstn is low, even with a valid request presented.
  always_comb begin
    fwd_ready    = 1'b1;
    sn_req_valid = '0;
    for (int i = 0; i < NUM_SN; i++) begin
      sn_req[i] = rstn ? mn_req : '0;
      if (tgt == SN_IDW'(i)) begin
        fwd_ready       = sn_req_ready[i];
        sn_req_valid[i] = rstn && mn_req_valid && !fifo_full;
      end
    end
  end

  assign mn_req_ready = rstn && !fifo_full && fwd_ready;
  assign push         = mn_req_valid && mn_req_ready;
  assign sn_tid       = rstn ? tgt : '0;

  always_comb begin
    mn_resp_valid = 1'b0;
    mn_resp       = '0;
    sn_resp_ready = '0;
    if (!fifo_empty) begin
`ifdef MEM_NOC_DECERR_EN
      if (head == SN_IDW'(NUM_SN)) mn_resp_valid = 1'b1;
`endif
      for (int i = 0; i < NUM_SN; i++) begin
        if (head == SN_IDW'(i)) begin
          mn_resp_valid    = sn_resp_valid[i];
          mn_resp          = sn_resp[i];
          sn_resp_ready[i] = mn_resp_ready;
        end
      end
    end
  end

  assign pop = mn_resp_valid && mn_resp_ready;

  noc_tid_fifo #(
    .WIDTH (SN_IDW),
    .DEPTH (MAX_OUTSTD)
  ) u_tid_fifo (
    .clk       (clk),
    .rstn      (rstn),
    .push      (push),
    .push_data (tgt),
    .pop       (pop),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (outstd_cnt),
    .head      (head)
  );

endmodule

// File: tb/tb_mem_noc_router_1ton.sv
// Self-checking bench for mem_noc_router_1ton (NUM_SN=4, MAX_OUTSTD=4): decode table, directed
// ordering/full/reset sequences and a randomized run against a queue-based reference model.
module tb_mem_noc_router_1ton;
  import mem_noc_router_1ton_pkg::*;

  localparam int unsigned NSn  = 4;
  localparam int unsigned NOut = 4;
  // Slave 3 overlaps slave 2's window, so 0x2xxx_xxxx exercises lowest-index priority.
  localparam logic [NSn-1:0][31:0] TbBase = {32'h2000_0000, 32'h2000_0000, 32'h1000_0000,
                                             32'h0000_0000};
  localparam logic [NSn-1:0][31:0] TbMask = {32'hE000_0000, 32'hF000_0000, 32'hF000_0000,
                                             32'hF000_0000};
`ifdef MEM_NOC_DECERR_EN
  localparam bit DecErr  = 1'b1;
  localparam int MissTgt = 4;
`else
  localparam bit DecErr  = 1'b0;
  localparam int MissTgt = 3;
`endif

  logic            clk = 1'b0;
  logic            rstn;
  logic            mn_req_valid, mn_req_ready;
  mem_req_t        mn_req;
  logic            mn_resp_valid, mn_resp_ready;
  mem_resp_t       mn_resp;
  logic [NSn-1:0]  sn_req_valid, sn_req_ready;
  mem_req_t        sn_req [NSn];
  logic [NSn-1:0]  sn_resp_valid, sn_resp_ready;
  mem_resp_t       sn_resp [NSn];
  logic [2:0]      sn_tid;
  logic [2:0]      outstd_cnt;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mem_noc_router_1ton #(
    .NUM_SN     (NSn),
    .MAX_OUTSTD (NOut),
    .SN_BASE    (TbBase),
    .SN_MASK    (TbMask)
  ) dut (
    .clk           (clk),
    .rstn          (rstn),
    .mn_req_valid  (mn_req_valid),
    .mn_req_ready  (mn_req_ready),
    .mn_req        (mn_req),
    .mn_resp_valid (mn_resp_valid),
    .mn_resp_ready (mn_resp_ready),
    .mn_resp       (mn_resp),
    .sn_req_valid  (sn_req_valid),
    .sn_req_ready  (sn_req_ready),
    .sn_req        (sn_req),
    .sn_resp_valid (sn_resp_valid),
    .sn_resp_ready (sn_resp_ready),
    .sn_resp       (sn_resp),
    .sn_tid        (sn_tid),
    .outstd_cnt    (outstd_cnt)
  );

  typedef struct {
    logic [31:0] addr;
    logic [3:0]  rdy;
    logic [2:0]  tid;
    logic        ready;
    logic [3:0]  valid;
  } vec_t;

  vec_t vecs [7];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Decode rule for this bench's map: top nibble 0..3 selects that slave, otherwise a miss.
  function automatic int model_tgt(input logic [31:0] addr);
    int n;
    n = int'(addr[31:28]);
    if (n < 4) return n;
    return MissTgt;
  endfunction

  task automatic settle();
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic idle();
    mn_req_valid  = 1'b0;
    mn_req        = '0;
    sn_req_ready  = '0;
    sn_resp_valid = '0;
    mn_resp_ready = 1'b0;
    for (int i = 0; i < NSn; i++) sn_resp[i] = '0;
  endtask

  task automatic do_reset();
    idle();
    rstn = 1'b0;
    @(negedge clk);
    rstn = 1'b1;
  endtask

  task automatic drive_req(input logic [31:0] addr);
    mn_req_valid     = 1'b1;
    mn_req.req_addr  = addr;
    mn_req.req_we    = 1'($urandom);
    mn_req.req_wdata = $urandom;
    mn_req.req_be    = 4'($urandom);
  endtask

  task automatic seq_reset_first();
    rstn = 1'b1;
    idle();
    #2 rstn = 1'b0;
    drive_req(32'h2000_0100);
    sn_req_ready  = 4'b1111;
    sn_resp_valid = 4'b1111;
    mn_resp_ready = 1'b1;
    @(negedge clk);
    settle();
    check("rst_sn_req_valid", 64'(sn_req_valid), 64'd0);
    check("rst_mn_req_ready", 64'(mn_req_ready), 64'd0);
    check("rst_mn_resp_valid", 64'(mn_resp_valid), 64'd0);
    check("rst_mn_resp", 64'(mn_resp), 64'd0);
    check("rst_sn_resp_ready", 64'(sn_resp_ready), 64'd0);
    check("rst_outstd_cnt", 64'(outstd_cnt), 64'd0);
    check("rst_sn_tid", 64'(sn_tid), 64'd0);
    @(negedge clk);
    idle();
    rstn = 1'b1;
    drive_req(32'h2000_0100);
    sn_req_ready = 4'b0100;
    settle();
    check("first_sn_req_valid", 64'(sn_req_valid), 64'h4);
    check("first_mn_req_ready", 64'(mn_req_ready), 64'd1);
    check("first_sn_tid", 64'(sn_tid), 64'd2);
    tick();
    mn_req_valid          = 1'b0;
    sn_resp_valid         = 4'b0100;
    sn_resp[2].resp_rdata = 32'hCAFE_0002;
    mn_resp_ready         = 1'b1;
    settle();
    check("first_cnt", 64'(outstd_cnt), 64'd1);
    check("first_resp_valid", 64'(mn_resp_valid), 64'd1);
    check("first_resp_data", 64'(mn_resp), 64'({32'hCAFE_0002, 1'b0}));
    check("first_sn_resp_ready", 64'(sn_resp_ready), 64'h4);
    tick();
    settle();
    check("first_drained_cnt", 64'(outstd_cnt), 64'd0);
  endtask

  task automatic seq_table();
    do_reset();
    foreach (vecs[k]) begin
      @(negedge clk);
      drive_req(vecs[k].addr);
      sn_req_ready = vecs[k].rdy;
      settle();
      check($sformatf("tbl%0d_tid", k), 64'(sn_tid), 64'(vecs[k].tid));
      check($sformatf("tbl%0d_ready", k), 64'(mn_req_ready), 64'(vecs[k].ready));
      check($sformatf("tbl%0d_valid", k), 64'(sn_req_valid), 64'(vecs[k].valid));
      mn_req_valid = 1'b0;
    end
    settle();
    check("tbl_cnt_untouched", 64'(outstd_cnt), 64'd0);
  endtask

  task automatic seq_full();
    do_reset();
    sn_req_ready = 4'b1111;
    for (int i = 0; i < 4; i++) begin
      drive_req({4'(i), 28'h0000100});
      settle();
      check("full_push_rdy", 64'(mn_req_ready), 64'd1);
      check("full_cnt_pre", 64'(outstd_cnt), 64'(i));
      tick();
    end
    drive_req(32'h0000_0200);
    settle();
    check("full_5th_rdy", 64'(mn_req_ready), 64'd0);
    check("full_5th_valid", 64'(sn_req_valid), 64'd0);
    check("full_cnt", 64'(outstd_cnt), 64'd4);
    sn_resp_valid = 4'b0001;
    mn_resp_ready = 1'b1;
    settle();
    check("full_pop_stall_rdy", 64'(mn_req_ready), 64'd0);
    check("full_pop_resp_valid", 64'(mn_resp_valid), 64'd1);
    tick();
    sn_resp_valid = '0;
    mn_resp_ready = 1'b0;
    settle();
    check("full_after_pop_cnt", 64'(outstd_cnt), 64'd3);
    check("full_freed_rdy", 64'(mn_req_ready), 64'd1);
  endtask

  task automatic seq_order();
    do_reset();
    sn_req_ready = 4'b0011;
    drive_req(32'h1000_0040);
    tick();
    drive_req(32'h0000_0040);
    tick();
    mn_req_valid          = 1'b0;
    sn_resp[0].resp_rdata = 32'hA0A0_0000;
    sn_resp[1].resp_rdata = 32'hB1B1_0001;
    sn_resp_valid         = 4'b0001;
    mn_resp_ready         = 1'b1;
    settle();
    check("ord_cnt", 64'(outstd_cnt), 64'd2);
    check("ord_blocked_rdy", 64'(sn_resp_ready), 64'h2);
    check("ord_blocked_valid", 64'(mn_resp_valid), 64'd0);
    tick();
    sn_resp_valid = 4'b0011;
    settle();
    check("ord_hold_cnt", 64'(outstd_cnt), 64'd2);
    check("ord_head1_valid", 64'(mn_resp_valid), 64'd1);
    check("ord_head1_data", 64'(mn_resp), 64'({32'hB1B1_0001, 1'b0}));
    tick();
    settle();
    check("ord_head0_rdy", 64'(sn_resp_ready), 64'h1);
    check("ord_head0_data", 64'(mn_resp), 64'({32'hA0A0_0000, 1'b0}));
    tick();
    settle();
    check("ord_drained_cnt", 64'(outstd_cnt), 64'd0);
  endtask

  task automatic seq_push_pop();
    do_reset();
    sn_req_ready = 4'b1111;
    drive_req(32'h0000_0000);
    tick();
    drive_req(32'h2000_0000);
    tick();
    drive_req(32'h1000_0000);
    sn_resp_valid         = 4'b0001;
    sn_resp[0].resp_rdata = 32'h0D0D_0000;
    mn_resp_ready         = 1'b1;
    settle();
    check("pp_cnt_before", 64'(outstd_cnt), 64'd2);
    check("pp_req_rdy", 64'(mn_req_ready), 64'd1);
    check("pp_resp0_data", 64'(mn_resp), 64'({32'h0D0D_0000, 1'b0}));
    tick();
    mn_req_valid          = 1'b0;
    sn_resp_valid         = 4'b0110;
    sn_resp[1].resp_rdata = 32'h1111_1111;
    sn_resp[2].resp_rdata = 32'h2222_2222;
    settle();
    check("pp_cnt_same", 64'(outstd_cnt), 64'd2);
    check("pp_head2_rdy", 64'(sn_resp_ready), 64'h4);
    check("pp_head2_data", 64'(mn_resp), 64'({32'h2222_2222, 1'b0}));
    tick();
    settle();
    check("pp_head1_rdy", 64'(sn_resp_ready), 64'h2);
    check("pp_head1_data", 64'(mn_resp), 64'({32'h1111_1111, 1'b0}));
    tick();
    settle();
    check("pp_drained_cnt", 64'(outstd_cnt), 64'd0);
  endtask

  task automatic seq_unmapped();
    do_reset();
    sn_req_ready = 4'b1000;
    drive_req(32'h8000_0010);
    settle();
    check("um_req_rdy", 64'(mn_req_ready), 64'd1);
    check("um_sn_tid", 64'(sn_tid), 64'(MissTgt));
    check("um_sn_req_valid", 64'(sn_req_valid), DecErr ? 64'd0 : 64'h8);
    tick();
    mn_req_valid          = 1'b0;
    sn_resp[3].resp_rdata = 32'h3333_3333;
    sn_resp_valid         = DecErr ? 4'b0000 : 4'b1000;
    mn_resp_ready         = 1'b1;
    settle();
    check("um_cnt", 64'(outstd_cnt), 64'd1);
    check("um_resp_valid", 64'(mn_resp_valid), 64'd1);
    check("um_resp_data", 64'(mn_resp), DecErr ? 64'd0 : 64'({32'h3333_3333, 1'b0}));
    check("um_sn_resp_ready", 64'(sn_resp_ready), DecErr ? 64'd0 : 64'h8);
    tick();
    settle();
    check("um_drained_cnt", 64'(outstd_cnt), 64'd0);
  endtask

  task automatic seq_mid_reset();
    do_reset();
    sn_req_ready = 4'b1111;
    for (int i = 0; i < 3; i++) begin
      drive_req({4'(i), 28'h0000040});
      tick();
    end
    mn_req_valid  = 1'b0;
    sn_resp_valid = 4'b1111;
    settle();
    check("mr_cnt_before", 64'(outstd_cnt), 64'd3);
    rstn = 1'b0;
    settle();
    check("mr_cnt_cleared", 64'(outstd_cnt), 64'd0);
    check("mr_resp_valid", 64'(mn_resp_valid), 64'd0);
    check("mr_sn_resp_ready", 64'(sn_resp_ready), 64'd0);
    @(negedge clk);
    rstn = 1'b1;
    idle();
  endtask

  task automatic seq_random(input int cycles);
    int          q [$];
    logic [3:0]  nib_tab [8];
    int          t, h, k;
    logic        full, e_rdy, e_rvld, do_push, do_pop;
    logic [3:0]  e_vld, e_srdy;
    mem_resp_t   e_resp;
    nib_tab = '{4'h0, 4'h1, 4'h2, 4'h3, 4'h3, 4'h2, 4'h8, 4'hF};
    do_reset();
    for (int c = 0; c < cycles; c++) begin
      if ($urandom_range(0, 9) < 6) drive_req({nib_tab[$urandom_range(0, 7)], 28'($urandom)});
      else mn_req_valid = 1'b0;
      sn_req_ready  = 4'($urandom);
      sn_resp_valid = 4'($urandom);
      mn_resp_ready = ($urandom_range(0, 3) != 0);
      for (int i = 0; i < NSn; i++) sn_resp[i] = {$urandom, 1'($urandom)};
      settle();
      t     = model_tgt(mn_req.req_addr);
      full  = (q.size() == NOut);
      e_rdy = !full && ((t < NSn) ? sn_req_ready[t] : 1'b1);
      e_vld = (mn_req_valid && !full && t < NSn) ? 4'(1 << t) : 4'd0;
      e_rvld = 1'b0;
      e_resp = '0;
      e_srdy = '0;
      if (q.size() > 0) begin
        h = q[0];
        if (h < NSn) begin
          e_rvld = sn_resp_valid[h];
          e_resp = sn_resp[h];
          e_srdy = mn_resp_ready ? 4'(1 << h) : 4'd0;
        end else begin
          e_rvld = 1'b1;
        end
      end
      k = $urandom_range(0, NSn - 1);
      check("rnd_cnt", 64'(outstd_cnt), 64'(q.size()));
      check("rnd_tid", 64'(sn_tid), 64'(t));
      check("rnd_req_rdy", 64'(mn_req_ready), 64'(e_rdy));
      check("rnd_sn_req_valid", 64'(sn_req_valid), 64'(e_vld));
      check("rnd_resp_valid", 64'(mn_resp_valid), 64'(e_rvld));
      check("rnd_resp", 64'(mn_resp), 64'(e_resp));
      check("rnd_sn_resp_ready", 64'(sn_resp_ready), 64'(e_srdy));
      check("rnd_bcast", 64'(sn_req[k] === mn_req), 64'd1);
      do_push = mn_req_valid && e_rdy;
      do_pop  = e_rvld && mn_resp_ready;
      tick();
      if (do_pop) void'(q.pop_front());
      if (do_push) q.push_back(t);
    end
  endtask

  initial begin
    vecs[0] = '{32'h0000_1000, 4'b0001, 3'd0, 1'b1, 4'b0001};
    vecs[1] = '{32'h1234_5678, 4'b0000, 3'd1, 1'b0, 4'b0010};
    vecs[2] = '{32'h2000_0000, 4'b1100, 3'd2, 1'b1, 4'b0100};
    vecs[3] = '{32'h3FFF_FFFC, 4'b0111, 3'd3, 1'b0, 4'b1000};
    vecs[4] = '{32'h3000_0000, 4'b1000, 3'd3, 1'b1, 4'b1000};
    vecs[5] = '{32'h8000_0000, 4'b0000, 3'(MissTgt), DecErr, DecErr ? 4'b0000 : 4'b1000};
    vecs[6] = '{32'hF000_0004, 4'b1000, 3'(MissTgt), 1'b1, DecErr ? 4'b0000 : 4'b1000};

    seq_reset_first();
    seq_table();
    seq_full();
    seq_order();
    seq_push_pop();
    seq_unmapped();
    seq_mid_reset();
    seq_random(3000);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached, got no finish, expected finish");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/mem_noc_router_1ton.md
MEM_NOC_ROUTER_1TON -- requirements
Module: mem_noc_router_1ton

Interface
REQ-001 SHALL have parameter NUM_SN, default 2: number of slave ports, 2..8.
REQ-002 SHALL have parameter MAX_OUTSTD, default 4: maximum outstanding requests, a power of 2, 2..16.
REQ-003 SHALL have parameter SN_IDW, default $clog2(NUM_SN+1): width of a target ID.
REQ-004 SHALL have parameters SN_BASE[NUM_SN] and SN_MASK[NUM_SN], defaults from urv_cfg: per-slave address window.
REQ-005 SHALL use one clock and an asynchronous active-low reset, with ports clk (input, 1 bit, clock) and rstn (input, 1 bit, asynchronous active-low reset).
REQ-006 SHALL have the master request ports mn_req_valid in 1, mn_req_ready out 1, and mn_req in mem_req_t.
REQ-007 SHALL have the master response ports mn_resp_valid out 1, mn_resp_ready in 1, and mn_resp out mem_resp_t.
REQ-008 SHALL have the slave request ports sn_req_valid out [NUM_SN], sn_req_ready in [NUM_SN], and sn_req out mem_req_t[NUM_SN].
REQ-009 SHALL have the slave response ports sn_resp_valid in [NUM_SN], sn_resp_ready out [NUM_SN], and sn_resp in mem_resp_t[NUM_SN].
REQ-010 SHALL have sn_tid out SN_IDW: the decoded target of the current mn_req.
REQ-011 SHALL have outstd_cnt out $clog2(MAX_OUTSTD+1): the number of in-flight requests.

Function
REQ-012 SHALL decode slave i as hit when (mn_req.req_addr & SN_MASK[i]) == SN_BASE[i]; the lowest index wins; miss gives tgt = NUM_SN.
REQ-013 SHALL broadcast mn_req to every sn_req[i] and assert sn_req_valid[i] = mn_req_valid && tgt==i && !full.
REQ-014 SHALL drive mn_req_ready = !full && (tgt<NUM_SN ? sn_req_ready[tgt] : 1).
REQ-015 SHALL push tgt into the ID FIFO on every mn_req handshake.
REQ-016 SHALL keep mn_req_ready independent of mn_resp handshakes, so no response-to-request combinational path exists.
REQ-017 SHALL stall requests when full (outstd_cnt==MAX_OUTSTD), even if a pop occurs in the same cycle; the freed slot is usable next cycle.
REQ-018 SHALL return responses strictly in request order; head = FIFO head ID when not empty.
REQ-019 SHALL drive mn_resp_valid = !empty && sn_resp_valid[head] and mn_resp = sn_resp[head].
REQ-020 SHALL drive sn_resp_ready[i] = !empty && head==i && mn_resp_ready; non-head slaves see ready=0.
REQ-021 SHALL pop the FIFO on a mn_resp handshake.
REQ-022 SHALL, on simultaneous push and pop, leave outstd_cnt unchanged and advance both pointers.
REQ-023 SHALL, when empty, drive mn_resp_valid=0, mn_resp='0 and all sn_resp_ready=0.
REQ-024 SHALL let pointers wrap modulo MAX_OUTSTD; the count never exceeds MAX_OUTSTD.
REQ-025 SHALL give zero-cycle request latency (combinational pass-through); a response is forwarded in the same cycle it is presented.
REQ-026 SHALL NOT drive any output combinationally from mn_resp_ready, except sn_resp_ready.

Reset
REQ-027 SHALL, on rstn low, immediately clear the FIFO pointers and outstd_cnt to 0, giving all *_valid=0 and mn_resp='0.
REQ-028 SHALL discard in-flight transactions on reset mid-operation; slaves are reset by the same rstn.

Configuration
REQ-029 SHALL, with MEM_NOC_DECERR_EN defined, accept unmapped requests locally (tgt=NUM_SN pushed); at the head, mn_resp_valid=1 and mn_resp='0 without any slave handshake.
REQ-030 SHALL, with MEM_NOC_DECERR_EN undefined, route a decode miss to slave NUM_SN-1, and no local responder exists.

Structure
REQ-031 SHALL define the address-map defaults (SN_BASE/SN_MASK arrays), MAX_OUTSTD defaults and noc_tgt_t in the urv_cfg/urv_typedef packages.
REQ-032 SHALL implement the ID FIFO as sub-module noc_tid_fifo (parameters WIDTH, DEPTH; push/pop/full/empty/count/head) using stdffrve flops.

Verification (NUM_SN=4, MAX_OUTSTD=4)
REQ-033 SHALL verify that reset with mn_req_valid=1 gives all outputs 0; after release, a req to slave 2 with sn_req_ready[2]=1 gives sn_req_valid[2]=1 in the same cycle and outstd_cnt=1.
REQ-034 SHALL verify that 4 back-to-back reqs to slaves 0,1,2,3 with no responses leave the 5th req with mn_req_ready=0 and outstd_cnt=4.
REQ-035 SHALL verify that reqs to slaves 1 then 0, with slave 0 responding first, give sn_resp_ready[0]=0 until slave 1's response transfers, then slave 0's response is forwarded.
REQ-036 SHALL verify that with outstd_cnt=2, a push and pop in the same cycle leave outstd_cnt at 2 and return responses in order.
REQ-037 SHALL verify that an unmapped address gives, with MEM_NOC_DECERR_EN, a handshake, mn_resp_valid=1 with mn_resp=0 at the head, and no sn_req_valid; without it, sn_req_valid[3]=1.
REQ-038 SHALL verify that rstn asserted with outstd_cnt=3 gives outstd_cnt=0 immediately and mn_resp_valid=0.
